dac_sample_feeder: RTL and testbench

Sample scheduler that sits directly upstream of the dual-channel DAC serializer. It buffers 12-bit samples tagged with a DAC channel in a small FIFO. On a fixed sample-rate tick it issues exactly one transfer to the serializer using the serializer's `go`/`dac_sel`/`data_in`/`ready` handshake. It also flags underruns, where the FIFO is empty at a tick, and late ticks, where a tick arrives while the previous one is still pending.

---
 rtl/dac_sample_feeder.sv | 145 ++++++++++++++
 tb/tb_dac_sample_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffered DAC sample scheduler issuing one serializer transfer per rate tick.
// Optional build macro DAC_SAMPLE_FEEDER_HOLD_EN: an empty-FIFO tick reissues the last issued sample.
module dac_sample_feeder #(
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_chan,
  input  logic [11:0]              s_data,
  input  logic                     drv_ready,
  output logic                     drv_go,
  output logic                     drv_dac_sel,
  output logic [11:0]              drv_data,
  output logic                     underrun,
  output logic                     late_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RATE_DIV);

  typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;

  state_t        state;
  state_t        state_next;
  logic [12:0]   mem [DEPTH];
  logic [12:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          pend_tick;
  logic          push;
  logic          pop;
  logic          empty;
  logic          clear_pend;
  logic          tick_taken;

  assign empty   = (level == '0);
  assign s_ready = (level != LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];
  assign tick    = (tick_cnt == CW'(RATE_DIV - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_chan, s_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A tick seen in IDLE with data ready is consumed directly, giving one cycle of tick-to-go latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_tick <= 1'b0;
      late_err  <= 1'b0;
    end else if (tick && !tick_taken) begin
      pend_tick <= 1'b1;
      if (pend_tick && !clear_pend) late_err <= 1'b1;
    end else if (clear_pend) begin
      pend_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_dac_sel <= 1'b0;
      drv_data    <= '0;
    end else if (pop) begin
      drv_dac_sel <= head[12];
      drv_data    <= head[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((pend_tick || tick) && !empty) state_next = PEND;
`ifdef DAC_SAMPLE_FEEDER_HOLD_EN
        else if (pend_tick)                state_next = PEND;
`endif
      end
      PEND:    if (drv_ready)  state_next = BUSY;
      BUSY:    if (!drv_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    underrun   = 1'b0;
    clear_pend = 1'b0;
    tick_taken = 1'b0;
    drv_go     = 1'b0;
    case (state)
      IDLE: begin
        clear_pend = pend_tick;
        if ((pend_tick || tick) && !empty) begin
          pop        = 1'b1;
          tick_taken = !pend_tick;
        end else if (pend_tick) begin
          underrun = 1'b1;
        end
      end
      PEND:    drv_go = drv_ready;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: scoreboard bench for dac_sample_feeder with a behavioural serializer model.
// Honours DAC_SAMPLE_FEEDER_HOLD_EN when the design is built with it.
module tb_dac_sample_feeder;

  localparam int DEPTH    = 8;
  localparam int RATE_DIV = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_chan = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_ready;
  logic        drv_ready;
  logic        drv_go;
  logic        drv_dac_sel;
  logic [11:0] drv_data;
  logic        underrun;
  logic        late_err;
  logic [3:0]  level;

  logic        ser_ready;
  logic        stall = 1'b0;
  int          ser_cnt;

  int          total = 0;
  int          bad = 0;
  int          cyc;
  int          go_count = 0;
  int          ur_count = 0;
  int          last_accept = -1;
  logic [12:0] exp_q[$];
  int          go_cyc_q[$];
  int          go_lvl_q[$];
  logic [12:0] last_exp;
  logic        prev_go;

  dac_sample_feeder #(.DEPTH(DEPTH), .RATE_DIV(RATE_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan),
    .s_data(s_data), .drv_ready(drv_ready), .drv_go(drv_go), .drv_dac_sel(drv_dac_sel),
    .drv_data(drv_data), .underrun(underrun), .late_err(late_err), .level(level)
  );

  always #5 clk = ~clk;

  assign drv_ready = ser_ready && !stall;

  // Serializer model: ready drops the cycle after go and stays low for a 16-cycle frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_ready <= 1'b1;
      ser_cnt   <= 0;
    end else if (drv_go) begin
      ser_ready <= 1'b0;
      ser_cnt   <= 16;
    end else if (ser_cnt > 0) begin
      ser_cnt <= ser_cnt - 1;
      if (ser_cnt == 1) ser_ready <= 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output monitor: every issued transfer is checked against the scoreboard queue.
  always @(negedge clk) begin
    logic [12:0] got;
    logic [12:0] want;
    if (!rst_n) begin
      last_exp = '0;
      prev_go  = 1'b0;
    end else begin
      if (drv_go) begin
        go_count++;
        go_cyc_q.push_back(cyc);
        go_lvl_q.push_back(int'(level));
        got = {drv_dac_sel, drv_data};
        total++;
        if (prev_go) begin
          bad++;
          $display("[TB] FAIL go_consecutive: drv_go high again at cycle %0d, required low", cyc);
        end
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          total++;
          if (got !== want) begin
            bad++;
            $display("[TB] FAIL go_sample: cycle %0d got %h required %h", cyc, got, want);
          end
          last_exp = want;
        end else begin
`ifdef DAC_SAMPLE_FEEDER_HOLD_EN
          total++;
          if (got !== last_exp) begin
            bad++;
            $display("[TB] FAIL go_hold: cycle %0d got %h required %h", cyc, got, last_exp);
          end
`else
          total++;
          bad++;
          $display("[TB] FAIL go_unexpected: cycle %0d got go with %h, required no go", cyc, got);
`endif
        end
      end
      total++;
      if (level > 4'd8) begin
        bad++;
        $display("[TB] FAIL level_bound: cycle %0d level %0d exceeds 8", cyc, level);
      end
      if (underrun) ur_count++;
      prev_go = drv_go;
    end
  end

  task automatic push_sample(input logic c, input logic [11:0] d);
    s_valid = 1'b1;
    s_chan  = c;
    s_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back({c, d});
        last_accept = cyc;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("[TB] FAIL push_timeout: sample %h not accepted in 200 cycles", {c, d});
  endtask

  task automatic wait_go(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drv_go) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL go_timeout: no drv_go within %0d cycles", budget);
  endtask

  task automatic wait_underrun(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (underrun) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL underrun_timeout: no underrun within %0d cycles", budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (level !== 4'd0)     begin bad++; $display("[TB] FAIL rst_level: got %0d required 0", level); end
    total++; if (s_ready !== 1'b1)   begin bad++; $display("[TB] FAIL rst_s_ready: got %b required 1", s_ready); end
    total++; if (drv_go !== 1'b0)    begin bad++; $display("[TB] FAIL rst_go: got %b required 0", drv_go); end
    total++; if ({drv_dac_sel, drv_data} !== 13'h0) begin bad++; $display("[TB] FAIL rst_drv: got %h required 0", {drv_dac_sel, drv_data}); end
    total++; if (underrun !== 1'b0)  begin bad++; $display("[TB] FAIL rst_underrun: got %b required 0", underrun); end
    total++; if (late_err !== 1'b0)  begin bad++; $display("[TB] FAIL rst_late: got %b required 0", late_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rate();
    int want_cyc [3] = '{20, 40, 60};
    int want_lvl [3] = '{2, 1, 0};
    go_cyc_q.delete();
    go_lvl_q.delete();
    push_sample(1'b0, 12'h123);
    push_sample(1'b1, 12'h456);
    push_sample(1'b0, 12'h789);
    s_valid = 1'b0;
    @(negedge clk);
    total++; if (level !== 4'd3) begin bad++; $display("[TB] FAIL rate_level_full: got %0d required 3", level); end
    repeat (3) wait_go(40);
    @(posedge clk);
    #1;
    total++;
    if (go_cyc_q.size() != 3) begin
      bad++;
      $display("[TB] FAIL rate_go_count: got %0d required 3", go_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (go_cyc_q[i] != want_cyc[i]) begin bad++; $display("[TB] FAIL rate_go_cycle%0d: got %0d required %0d", i, go_cyc_q[i], want_cyc[i]); end
        total++;
        if (go_lvl_q[i] != want_lvl[i]) begin bad++; $display("[TB] FAIL rate_level%0d: got %0d required %0d", i, go_lvl_q[i], want_lvl[i]); end
      end
    end
  endtask

  task automatic test_underrun();
    int g0 = go_count;
    wait_underrun(40);
    total++; if (cyc != 80) begin bad++; $display("[TB] FAIL underrun_cycle: got %0d required 80", cyc); end
    total++; if (drv_go !== 1'b0) begin bad++; $display("[TB] FAIL underrun_go_same: got %b required 0", drv_go); end
    @(negedge clk);
    total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL underrun_pulse: got %b required 0", underrun); end
    repeat (4) @(negedge clk);
`ifdef DAC_SAMPLE_FEEDER_HOLD_EN
    total++; if (go_count != g0 + 1) begin bad++; $display("[TB] FAIL underrun_hold_go: got %0d required %0d", go_count - g0, 1); end
`else
    total++; if (go_count != g0) begin bad++; $display("[TB] FAIL underrun_no_go: got %0d required 0", go_count - g0); end
`endif
  endtask

  task automatic test_back_to_back();
    int u;
    wait_underrun(40);
    u = cyc;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_sample(i[0], 12'hA00 + 12'(i));
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_s_ready: got %b required 0", s_ready); end
    total++; if (level !== 4'd8)   begin bad++; $display("[TB] FAIL full_level: got %0d required 8", level); end
    @(posedge clk);
    #1;
    push_sample(1'b1, 12'hABC);
    s_valid = 1'b0;
    total++; if (last_accept != u + 20) begin bad++; $display("[TB] FAIL ninth_accept: got cycle %0d required %0d", last_accept, u + 20); end
    total++; if (go_cyc_q[$] != u + 20) begin bad++; $display("[TB] FAIL first_pop_go: got cycle %0d required %0d", go_cyc_q[$], u + 20); end
  endtask

  task automatic test_stall();
    int snap;
    wait_go(40);
    repeat (15) @(posedge clk);
    #1;
    stall = 1'b1;
    snap = go_count;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 25) begin
        total++; if (late_err !== 1'b0) begin bad++; $display("[TB] FAIL late_early: got %b required 0", late_err); end
      end
      @(posedge clk);
      #1;
    end
    total++; if (go_count != snap) begin bad++; $display("[TB] FAIL stall_go: got %0d gos during stall required 0", go_count - snap); end
    stall = 1'b0;
    @(negedge clk);
    total++; if (drv_go !== 1'b1)   begin bad++; $display("[TB] FAIL stall_release_go: got %b required 1", drv_go); end
    total++; if (late_err !== 1'b1) begin bad++; $display("[TB] FAIL late_set: got %b required 1", late_err); end
    repeat (30) @(negedge clk);
    total++; if (late_err !== 1'b1) begin bad++; $display("[TB] FAIL late_sticky: got %b required 1", late_err); end
  endtask

  task automatic test_reset_busy();
    int g0;
    int u0;
    for (int i = 0; i < 400 && level != 4'd0; i++) @(negedge clk);
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL drain_timeout: level %0d required 0", level); end
    wait_underrun(60);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push_sample(1'b1, 12'h5A0 + 12'(i));
    s_valid = 1'b0;
    wait_go(60);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total++; if (level !== 4'd4)    begin bad++; $display("[TB] FAIL busy_level: got %0d required 4", level); end
    total++; if (late_err !== 1'b1) begin bad++; $display("[TB] FAIL busy_late: got %b required 1", late_err); end
    rst_n = 1'b0;
    #1;
    total++; if (level !== 4'd0)     begin bad++; $display("[TB] FAIL mid_rst_level: got %0d required 0", level); end
    total++; if (s_ready !== 1'b1)   begin bad++; $display("[TB] FAIL mid_rst_s_ready: got %b required 1", s_ready); end
    total++; if (drv_go !== 1'b0)    begin bad++; $display("[TB] FAIL mid_rst_go: got %b required 0", drv_go); end
    total++; if ({drv_dac_sel, drv_data} !== 13'h0) begin bad++; $display("[TB] FAIL mid_rst_drv: got %h required 0", {drv_dac_sel, drv_data}); end
    total++; if (underrun !== 1'b0)  begin bad++; $display("[TB] FAIL mid_rst_underrun: got %b required 0", underrun); end
    total++; if (late_err !== 1'b0)  begin bad++; $display("[TB] FAIL mid_rst_late: got %b required 0", late_err); end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g0 = go_count;
    u0 = ur_count;
    repeat (70) @(negedge clk);
`ifdef DAC_SAMPLE_FEEDER_HOLD_EN
    total++; if (go_count != g0 + 3) begin bad++; $display("[TB] FAIL post_rst_go: got %0d required 3", go_count - g0); end
`else
    total++; if (go_count != g0) begin bad++; $display("[TB] FAIL post_rst_go: got %0d required 0", go_count - g0); end
`endif
    total++; if (ur_count != u0 + 3) begin bad++; $display("[TB] FAIL post_rst_underrun: got %0d required 3", ur_count - u0); end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_underrun();
    test_back_to_back();
    test_stall();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
